gray_key_encoder: RTL and testbench
===================================

GRAY_KEY_ENCODER -- requirements
Module: gray_key_encoder

Interface
REQ-001 SHALL have parameter NR_KEY, default 4, number of table entries (2..256).
REQ-002 SHALL have parameter KEY_WIDTH, default 4, key width in bits.
REQ-003 SHALL have parameter IDX_WIDTH, default 2, index width; SHALL satisfy 2**IDX_WIDTH >= NR_KEY.
REQ-004 SHALL have parameter GRAY, default 1; 1 = index output Gray-coded (i ^ (i >> 1)), 0 = plain binary.
REQ-005 SHALL have parameter DEF_IDX, default 0, index value driven on a miss (emitted raw, never encoded).
REQ-006 SHALL have parameter CNT_WIDTH, default 8, miss-counter width.
REQ-007 clk  in  1  sole clock, rising edge.
REQ-008 rst_n  in  1  asynchronous, active-low reset.
REQ-009 wr_en  in  1  table write strobe.
REQ-010 wr_idx  in  IDX_WIDTH  entry to write, binary.
REQ-011 wr_key  in  KEY_WIDTH  key stored into entry wr_idx.
REQ-012 clr  in  1  invalidate all entries.
REQ-013 in_valid  in  1  lookup request valid.
REQ-014 in_ready  out  1  block accepts lookup.
REQ-015 in_key  in  KEY_WIDTH  key to look up.
REQ-016 out_valid  out  1  result valid.
REQ-017 out_ready  in  1  consumer accepts result.
REQ-018 out_hit  out  1  1 = key matched a valid entry.
REQ-019 out_idx  out  IDX_WIDTH  matched index, encoded per GRAY, or DEF_IDX on miss.
REQ-020 miss_cnt  out  CNT_WIDTH  saturating count of accepted lookups that missed.

Function
REQ-021 Table SHALL hold NR_KEY registered (key, valid) pairs.
REQ-022 On clk edge with wr_en=1, clr=0, and wr_idx < NR_KEY: entry wr_idx key <= wr_key, valid <= 1.
REQ-023 wr_en with wr_idx >= NR_KEY SHALL be ignored; no state changes.
REQ-024 clr=1 SHALL clear all valid bits at the edge; a coincident wr_en SHALL be ignored (clr wins).
REQ-025 in_ready SHALL equal (!out_valid || out_ready), combinationally.
REQ-026 Lookup SHALL be accepted on an edge where in_valid && in_ready.
REQ-027 Latency SHALL be 1 cycle: the result registers at the accept edge and out_valid=1 the following cycle.
REQ-028 Match SHALL compare in_key against the table contents before the accept edge; a write, or a clr, on that same edge SHALL NOT affect the lookup.
REQ-029 On multiple matching valid entries, the lowest index SHALL win.
REQ-030 Hit: out_hit=1; out_idx = i ^ (i >> 1) if GRAY=1, else i; width truncated to IDX_WIDTH.
REQ-031 Miss: out_hit=0, out_idx=DEF_IDX.
REQ-032 While out_valid && !out_ready: out_hit, out_idx, and out_valid SHALL hold stable, and no new lookup is accepted.
REQ-033 If out_valid && out_ready and no accept occurs, out_valid SHALL drop to 0 at the edge.
REQ-034 Back-to-back: accept and drain on the same edge SHALL sustain one result per cycle.
REQ-035 miss_cnt SHALL increment by 1 per accepted missing lookup, saturate at all-ones, and never wrap.
REQ-036 clr SHALL NOT reset miss_cnt.

Reset
REQ-037 rst_n=0 SHALL immediately, and asynchronously, clear: all valid bits, keys to 0, out_valid=0, out_hit=0, out_idx=0, miss_cnt=0.
REQ-038 After reset, in_ready=1.
REQ-039 Reset mid-transaction SHALL discard the pending result; no spurious out_valid after release.
REQ-040 Reset deassertion is synchronised externally; the block requires no internal synchroniser.

Verification
REQ-041 Defaults: write keys 3,5,9,C at entries 0..3; look up 9 -> next cycle out_valid=1, out_hit=1, out_idx=3 (gray of 2); with GRAY=0 -> out_idx=2.
REQ-042 Miss and saturation: CNT_WIDTH=2; 5 lookups of key F on an empty table -> out_hit=0 and out_idx=DEF_IDX each time; miss_cnt sequence 1,2,3,3,3.
REQ-043 Backpressure: out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0, outputs frozen; out_ready=1 -> one result per cycle, no loss or duplication.
REQ-044 Same-edge hazard: entry 1 key=7; clr and a lookup of 7 accepted on the same edge -> hit, idx=gray(1)=1; next lookup of 7 -> miss.
REQ-045 Priority and illegal writes: entries 1 and 2 both key=A -> lookup A gives idx=gray(1)=1; with NR_KEY=3, a write to wr_idx=3 -> no table change.
REQ-046 Async reset: assert rst_n=0 between edges while out_valid=1 -> out_valid=0 immediately, miss_cnt=0, all lookups miss after release.

Source files
------------

// File: rtl/gray_key_encoder.sv
// Key-to-index lookup table with a one-deep output register, optional Gray
// encoding of the matched index and a saturating miss counter.
module gray_key_encoder #(
  parameter int unsigned NR_KEY    = 4,
  parameter int unsigned KEY_WIDTH = 4,
  parameter int unsigned IDX_WIDTH = 2,
  parameter int unsigned GRAY      = 1,
  parameter int unsigned DEF_IDX   = 0,
  parameter int unsigned CNT_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 wr_en,
  input  logic [IDX_WIDTH-1:0] wr_idx,
  input  logic [KEY_WIDTH-1:0] wr_key,
  input  logic                 clr,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [KEY_WIDTH-1:0] in_key,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 out_hit,
  output logic [IDX_WIDTH-1:0] out_idx,
  output logic [CNT_WIDTH-1:0] miss_cnt
);

  localparam logic [IDX_WIDTH-1:0] DEF_IDX_V = IDX_WIDTH'(DEF_IDX);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX   = '1;

  logic [KEY_WIDTH-1:0] r_key [NR_KEY];
  logic [NR_KEY-1:0]    r_valid;
  logic                 r_out_valid;
  logic                 r_out_hit;
  logic [IDX_WIDTH-1:0] r_out_idx;
  logic [CNT_WIDTH-1:0] r_miss_cnt;

  logic                 w_accept;
  logic                 w_hit;
  logic [IDX_WIDTH-1:0] w_bin_idx;
  logic [IDX_WIDTH-1:0] w_enc_idx;

  assign in_ready  = !r_out_valid || out_ready;
  assign w_accept  = in_valid && in_ready;
  assign out_valid = r_out_valid;
  assign out_hit   = r_out_hit;
  assign out_idx   = r_out_idx;
  assign miss_cnt  = r_miss_cnt;

  // Priority match over the current table contents; the lowest index wins.
  always_comb begin
    w_hit     = 1'b0;
    w_bin_idx = '0;
    for (int i = 0; i < int'(NR_KEY); i++) begin
      if (!w_hit && r_valid[i] && (r_key[i] == in_key)) begin
        w_hit     = 1'b1;
        w_bin_idx = IDX_WIDTH'(i);
      end
    end
  end

  assign w_enc_idx = (GRAY != 0) ? (w_bin_idx ^ (w_bin_idx >> 1)) : w_bin_idx;

  // Table storage; clr beats a coincident write, out-of-range writes match no entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= '0;
      for (int i = 0; i < int'(NR_KEY); i++) begin
        r_key[i] <= '0;
      end
    end else if (clr) begin
      r_valid <= '0;
    end else if (wr_en) begin
      for (int i = 0; i < int'(NR_KEY); i++) begin
        if (wr_idx == IDX_WIDTH'(i)) begin
          r_key[i]   <= wr_key;
          r_valid[i] <= 1'b1;
        end
      end
    end
  end

  // Result register: load on accept, drop when drained without a new accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out_hit   <= 1'b0;
      r_out_idx   <= '0;
    end else if (w_accept) begin
      r_out_valid <= 1'b1;
      r_out_hit   <= w_hit;
      r_out_idx   <= w_hit ? w_enc_idx : DEF_IDX_V;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  // Saturating miss counter, untouched by clr.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_miss_cnt <= '0;
    end else if (w_accept && !w_hit && (r_miss_cnt != CNT_MAX)) begin
      r_miss_cnt <= r_miss_cnt + CNT_WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_gray_key_encoder.sv
// Directed bench: dut A uses defaults (Gray, 4 entries, 8-bit counter);
// dut B is binary, 3 entries, DEF_IDX=2, 2-bit counter. Both share inputs.
module tb_gray_key_encoder;

  logic       clk = 1'b0;
  logic       rst_n, wr_en, clr, in_valid, out_ready;
  logic [1:0] wr_idx;
  logic [3:0] wr_key, in_key;

  logic       a_in_ready, a_out_valid, a_out_hit;
  logic [1:0] a_out_idx;
  logic [7:0] a_miss_cnt;
  logic       b_in_ready, b_out_valid, b_out_hit;
  logic [1:0] b_out_idx;
  logic [1:0] b_miss_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  gray_key_encoder u_dut_a (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_idx(wr_idx), .wr_key(wr_key),
    .clr(clr), .in_valid(in_valid), .in_ready(a_in_ready), .in_key(in_key),
    .out_valid(a_out_valid), .out_ready(out_ready), .out_hit(a_out_hit),
    .out_idx(a_out_idx), .miss_cnt(a_miss_cnt)
  );

  gray_key_encoder #(
    .NR_KEY(3), .KEY_WIDTH(4), .IDX_WIDTH(2), .GRAY(0), .DEF_IDX(2), .CNT_WIDTH(2)
  ) u_dut_b (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_idx(wr_idx), .wr_key(wr_key),
    .clr(clr), .in_valid(in_valid), .in_ready(b_in_ready), .in_key(in_key),
    .out_valid(b_out_valid), .out_ready(out_ready), .out_hit(b_out_hit),
    .out_idx(b_out_idx), .miss_cnt(b_miss_cnt)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic write_entry(input logic [1:0] idx, input logic [3:0] key);
    wr_en = 1'b1; wr_idx = idx; wr_key = key;
    step();
    wr_en = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; wr_en = 1'b0; wr_idx = '0; wr_key = '0; clr = 1'b0;
    in_valid = 1'b0; in_key = '0; out_ready = 1'b1;
    step(); step();
    checks++;
    if ({a_out_valid, a_out_hit, a_out_idx, a_miss_cnt, a_in_ready} !== {4'b0000, 8'd0, 1'b1}) begin
      errors++;
      $display("FAIL reset_a got v%b h%b i%0d c%0d r%b", a_out_valid, a_out_hit, a_out_idx, a_miss_cnt, a_in_ready);
    end
    checks++;
    if ({b_out_valid, b_out_hit, b_out_idx, b_miss_cnt, b_in_ready} !== {4'b0000, 2'd0, 1'b1}) begin
      errors++;
      $display("FAIL reset_b got v%b h%b i%0d c%0d r%b", b_out_valid, b_out_hit, b_out_idx, b_miss_cnt, b_in_ready);
    end
    #3 rst_n = 1'b1;
    step();
  endtask

  task automatic test_lookup();
    logic [3:0] keys [3];
    logic [3:0] exp_a [3];
    logic [3:0] exp_b [3];
    logic [1:0] exp_cb [3];
    keys   = '{4'h9, 4'hC, 4'h3};
    exp_a  = '{4'b1111, 4'b1110, 4'b1100};  // gray(2)=3, gray(3)=2, gray(0)=0
    exp_b  = '{4'b1110, 4'b1010, 4'b1100};  // binary 2, miss->DEF 2, 0
    exp_cb = '{2'd0, 2'd1, 2'd1};
    write_entry(2'd0, 4'h3);
    write_entry(2'd1, 4'h5);
    write_entry(2'd2, 4'h9);
    write_entry(2'd3, 4'hC);  // out of range for dut B
    for (int k = 0; k < 3; k++) begin
      in_valid = 1'b1; in_key = keys[k];
      step();
      checks++;
      if ({a_out_valid, a_out_hit, a_out_idx} !== exp_a[k]) begin
        errors++;
        $display("FAIL lookup_a[%0d] got %b exp %b", k, {a_out_valid, a_out_hit, a_out_idx}, exp_a[k]);
      end
      checks++;
      if ({b_out_valid, b_out_hit, b_out_idx} !== exp_b[k] || b_miss_cnt !== exp_cb[k]) begin
        errors++;
        $display("FAIL lookup_b[%0d] got %b cnt %0d exp %b cnt %0d", k,
                 {b_out_valid, b_out_hit, b_out_idx}, b_miss_cnt, exp_b[k], exp_cb[k]);
      end
    end
    in_valid = 1'b0;
    step();
    checks++;
    if ({a_out_valid, b_out_valid, a_miss_cnt} !== {2'b00, 8'd0}) begin
      errors++;
      $display("FAIL drain got va%b vb%b ca%0d exp 0 0 0", a_out_valid, b_out_valid, a_miss_cnt);
    end
  endtask

  task automatic test_priority();
    write_entry(2'd1, 4'hA);
    write_entry(2'd2, 4'hA);
    in_valid = 1'b1; in_key = 4'hA;
    step();
    in_valid = 1'b0;
    checks++;
    if ({a_out_valid, a_out_hit, a_out_idx, b_out_valid, b_out_hit, b_out_idx} !== 8'b1101_1101) begin
      errors++;
      $display("FAIL priority got a%b b%b exp 1101 1101",
               {a_out_valid, a_out_hit, a_out_idx}, {b_out_valid, b_out_hit, b_out_idx});
    end
    step();
  endtask

  task automatic test_backpressure();
    in_valid = 1'b1; in_key = 4'h3; out_ready = 1'b0;
    step();
    in_key = 4'hC;
    for (int k = 0; k < 3; k++) begin
      checks++;
      if ({a_in_ready, a_out_valid, a_out_hit, a_out_idx, b_in_ready, b_out_valid, b_out_hit, b_out_idx}
          !== 10'b0_1100_0_1100) begin
        errors++;
        $display("FAIL hold[%0d] got ra%b a%b rb%b b%b exp 0 1100 0 1100", k, a_in_ready,
                 {a_out_valid, a_out_hit, a_out_idx}, b_in_ready, {b_out_valid, b_out_hit, b_out_idx});
      end
      step();
    end
    out_ready = 1'b1;
    #1;
    checks++;
    if ({a_in_ready, b_in_ready} !== 2'b11) begin
      errors++;
      $display("FAIL ready_comb got %b%b exp 11", a_in_ready, b_in_ready);
    end
    step();
    in_key = 4'hA;
    checks++;
    if ({a_out_valid, a_out_hit, a_out_idx, b_out_valid, b_out_hit, b_out_idx, b_miss_cnt} !== 10'b1110_1010_10) begin
      errors++;
      $display("FAIL b2b_0 got a%b b%b cb%0d exp 1110 1010 2",
               {a_out_valid, a_out_hit, a_out_idx}, {b_out_valid, b_out_hit, b_out_idx}, b_miss_cnt);
    end
    step();
    in_valid = 1'b0;
    checks++;
    if ({a_out_valid, a_out_hit, a_out_idx, b_out_valid, b_out_hit, b_out_idx} !== 8'b1101_1101) begin
      errors++;
      $display("FAIL b2b_1 got a%b b%b exp 1101 1101",
               {a_out_valid, a_out_hit, a_out_idx}, {b_out_valid, b_out_hit, b_out_idx});
    end
    step();
    checks++;
    if ({a_out_valid, b_out_valid} !== 2'b00) begin
      errors++;
      $display("FAIL b2b_drain got %b%b exp 00", a_out_valid, b_out_valid);
    end
  endtask

  task automatic test_same_edge();
    write_entry(2'd1, 4'h7);
    clr = 1'b1; wr_en = 1'b1; wr_idx = 2'd0; wr_key = 4'h7;
    in_valid = 1'b1; in_key = 4'h7;
    step();
    clr = 1'b0; wr_en = 1'b0;
    checks++;
    if ({a_out_valid, a_out_hit, a_out_idx, b_out_valid, b_out_hit, b_out_idx} !== 8'b1101_1101) begin
      errors++;
      $display("FAIL same_edge got a%b b%b exp 1101 1101",
               {a_out_valid, a_out_hit, a_out_idx}, {b_out_valid, b_out_hit, b_out_idx});
    end
    step();
    in_valid = 1'b0;
    checks++;
    if ({a_out_valid, a_out_hit, a_out_idx, a_miss_cnt, b_out_valid, b_out_hit, b_out_idx, b_miss_cnt}
        !== {4'b1000, 8'd1, 4'b1010, 2'd3}) begin
      errors++;
      $display("FAIL after_clr got a%b ca%0d b%b cb%0d exp 1000 1 1010 3",
               {a_out_valid, a_out_hit, a_out_idx}, a_miss_cnt, {b_out_valid, b_out_hit, b_out_idx}, b_miss_cnt);
    end
    step();
  endtask

  task automatic test_async_reset();
    write_entry(2'd0, 4'h3);
    in_valid = 1'b1; in_key = 4'h3; out_ready = 1'b0;
    step();
    in_valid = 1'b0;
    checks++;
    if ({a_out_valid, a_out_hit, b_out_valid, b_out_hit} !== 4'b1111) begin
      errors++;
      $display("FAIL pre_reset got %b%b%b%b exp 1111", a_out_valid, a_out_hit, b_out_valid, b_out_hit);
    end
    #3 rst_n = 1'b0;
    #1;
    checks++;
    if ({a_out_valid, a_out_hit, a_out_idx, a_miss_cnt, b_out_valid, b_out_hit, b_out_idx, b_miss_cnt,
         a_in_ready, b_in_ready} !== {4'b0000, 8'd0, 4'b0000, 2'd0, 2'b11}) begin
      errors++;
      $display("FAIL async_reset got a%b ca%0d b%b cb%0d r%b%b exp zeros, ready 11",
               {a_out_valid, a_out_hit, a_out_idx}, a_miss_cnt, {b_out_valid, b_out_hit, b_out_idx},
               b_miss_cnt, a_in_ready, b_in_ready);
    end
    @(posedge clk);
    #2 rst_n = 1'b1;
    out_ready = 1'b1;
    step();
    checks++;
    if ({a_out_valid, b_out_valid} !== 2'b00) begin
      errors++;
      $display("FAIL post_reset_valid got %b%b exp 00", a_out_valid, b_out_valid);
    end
  endtask

  task automatic test_miss_saturation();
    logic [3:0] keys [5];
    logic [1:0] exp_cb [5];
    keys   = '{4'h3, 4'hF, 4'hF, 4'hF, 4'hF};
    exp_cb = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
    for (int k = 0; k < 5; k++) begin
      in_valid = 1'b1; in_key = keys[k];
      step();
      checks++;
      if ({a_out_valid, a_out_hit, a_out_idx} !== 4'b1000 || a_miss_cnt !== 8'(k + 1)) begin
        errors++;
        $display("FAIL miss_a[%0d] got %b cnt %0d exp 1000 cnt %0d", k,
                 {a_out_valid, a_out_hit, a_out_idx}, a_miss_cnt, k + 1);
      end
      checks++;
      if ({b_out_valid, b_out_hit, b_out_idx} !== 4'b1010 || b_miss_cnt !== exp_cb[k]) begin
        errors++;
        $display("FAIL miss_b[%0d] got %b cnt %0d exp 1010 cnt %0d", k,
                 {b_out_valid, b_out_hit, b_out_idx}, b_miss_cnt, exp_cb[k]);
      end
    end
    in_valid = 1'b0;
    step();
  endtask

  initial begin
    test_reset();
    test_lookup();
    test_priority();
    test_backpressure();
    test_same_edge();
    test_async_reset();
    test_miss_saturation();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
